// File: rtl/descramble.sv
// descramble: x^11+x^9+1 idle-locked descrambler.
// Acquires lock from all-ones idle and drops it when idle runs stop.
module descramble #(
    parameter int LOCK_IDLES = 30,
    parameter int IDLE_RUN   = 29,
    parameter int LOCK_TIME  = 90000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scrambled,
    input  logic valid,
    output logic descrambled,
    output logic descrambled_valid,
    output logic locked
);

    localparam int MW = $clog2(LOCK_IDLES + 1);
    localparam int RW = $clog2(IDLE_RUN + 1);
    localparam int TW = $clog2(LOCK_TIME + 1);

    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_IDLES);
    localparam logic [RW-1:0] RUN_MAX   = RW'(IDLE_RUN);
    localparam logic [TW-1:0] TIME_MAX  = TW'(LOCK_TIME);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } state_t;

    state_t        state;
    logic [10:0]   lfsr;
    logic [MW-1:0] match_cnt;
    logic [RW-1:0] run_cnt;
    logic [TW-1:0] lock_tmr;

    logic          pred;
    logic          out_bit;
    logic          match;
    logic          out_en;
    logic [MW-1:0] match_inc;
    logic [RW-1:0] run_nxt;
    logic [TW-1:0] tmr_inc;
    logic          restart;
    logic          expire;

    always_comb begin
        pred    = lfsr[8] ^ lfsr[10];
        out_bit = scrambled ^ pred;
        out_en  = valid && (state == LOCKED);
        // a zero LFSR predicts zero forever, so it must never count
        match   = ((~scrambled) == pred) && (lfsr != '0);

        if (match_cnt >= MATCH_MAX) begin
            match_inc = match_cnt;
        end else begin
            match_inc = match_cnt + MW'(1);
        end

        if (!out_bit) begin
            run_nxt = '0;
        end else if (run_cnt >= RUN_MAX) begin
            run_nxt = run_cnt;
        end else begin
            run_nxt = run_cnt + RW'(1);
        end

        if (lock_tmr >= TIME_MAX) begin
            tmr_inc = lock_tmr;
        end else begin
            tmr_inc = lock_tmr + TW'(1);
        end

        restart = (run_nxt == RUN_MAX);
        expire  = (tmr_inc == TIME_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= UNLOCKED;
            lfsr              <= '0;
            match_cnt         <= '0;
            run_cnt           <= '0;
            lock_tmr          <= '0;
            descrambled       <= 1'b0;
            descrambled_valid <= 1'b0;
            locked            <= 1'b0;
        end else begin
            descrambled_valid <= out_en;
            descrambled       <= out_en && out_bit;
            if (valid) begin
                unique case (state)
                    UNLOCKED: begin
                        lfsr <= {lfsr[9:0], ~scrambled};
                        if (!match) begin
                            match_cnt <= '0;
                        end else if (match_inc == MATCH_MAX) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            run_cnt   <= '0;
                            lock_tmr  <= '0;
                        end else begin
                            match_cnt <= match_inc;
                        end
                    end
                    LOCKED: begin
                        lfsr <= {lfsr[9:0], pred};
                        // an idle run on the expiry bit still keeps lock
                        if (restart) begin
                            run_cnt  <= '0;
                            lock_tmr <= '0;
                        end else if (expire) begin
                            state     <= UNLOCKED;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            run_cnt   <= '0;
                            lock_tmr  <= '0;
                        end else begin
                            run_cnt  <= run_nxt;
                            lock_tmr <= tmr_inc;
                        end
                    end
                    default: begin
                        state <= UNLOCKED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_descramble.sv
// tb_descramble: directed checks of lock acquisition, data path,
// valid gaps, lock timeout and reset for descramble.
module tb_descramble;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scr_a, val_a, desc_a, dv_a, locked_a;
    logic        scr_b, val_b, desc_b, dv_b, locked_b;
    logic [10:0] tx_a, tx_b;
    int          n_chk;
    int          n_pass;

    always #5 clk = ~clk;

    descramble dut_a (
        .clk               (clk),
        .rst_n             (rst_n),
        .scrambled         (scr_a),
        .valid             (val_a),
        .descrambled       (desc_a),
        .descrambled_valid (dv_a),
        .locked            (locked_a)
    );

    descramble #(
        .LOCK_IDLES (30),
        .IDLE_RUN   (29),
        .LOCK_TIME  (100)
    ) dut_b (
        .clk               (clk),
        .rst_n             (rst_n),
        .scrambled         (scr_b),
        .valid             (val_b),
        .descrambled       (desc_b),
        .descrambled_valid (dv_b),
        .locked            (locked_b)
    );

    task automatic step_a(input logic d, input logic v);
        logic p;
        p     = tx_a[8] ^ tx_a[10];
        val_a = v;
        scr_a = d ^ p;
        if (v) tx_a = {tx_a[9:0], p};
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic d, input logic v);
        logic p;
        p     = tx_b[8] ^ tx_b[10];
        val_b = v;
        scr_b = d ^ p;
        if (v) tx_b = {tx_b[9:0], p};
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        val_a = 1'b0;
        val_b = 1'b0;
        scr_a = 1'b0;
        scr_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        val_a = 1'b0;
        val_b = 1'b0;
        scr_a = 1'b1;
        scr_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({locked_a, dv_a, desc_a} !== 3'b000)
            $display("FAIL reset_a: got %b want 000", {locked_a, dv_a, desc_a});
        else n_pass++;
        n_chk++;
        if ({locked_b, dv_b, desc_b} !== 3'b000)
            $display("FAIL reset_b: got %b want 000", {locked_b, dv_b, desc_b});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_stuck_high;
        int lk;
        int outs;
        lk   = 0;
        outs = 0;
        apply_reset;
        scr_a = 1'b1;
        val_a = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (locked_a !== 1'b0) lk++;
            if (dv_a !== 1'b0 || desc_a !== 1'b0) outs++;
        end
        val_a = 1'b0;
        n_chk++;
        if (lk != 0) $display("FAIL stuck_locked: got %0d locked cycles want 0", lk);
        else n_pass++;
        n_chk++;
        if (outs != 0) $display("FAIL stuck_outputs: got %0d active cycles want 0", outs);
        else n_pass++;
    endtask

    // Seed 7ff: bits 0..9 leave the LFSR zero, bit 10 mispredicts,
    // then bits 11..40 are the 30 matches, so lock lands on bit index 40.
    task automatic test_acquire;
        int   lock_at;
        logic dv_lock;
        int   bad;
        lock_at = -1;
        dv_lock = 1'b1;
        bad     = 0;
        apply_reset;
        tx_a = 11'h7ff;
        for (int i = 0; i < 60; i++) begin
            step_a(1'b1, 1'b1);
            if (lock_at < 0 && locked_a === 1'b1) begin
                lock_at = i;
                dv_lock = dv_a;
            end else if (lock_at >= 0) begin
                if (dv_a !== 1'b1 || desc_a !== 1'b1 || locked_a !== 1'b1) bad++;
            end else if (desc_a !== 1'b0 || dv_a !== 1'b0) begin
                bad++;
            end
        end
        n_chk++;
        if (lock_at != 40) $display("FAIL acq_lock_bit: got %0d want 40", lock_at);
        else n_pass++;
        n_chk++;
        if (dv_lock !== 1'b0) $display("FAIL acq_lock_bit_dv: got %b want 0", dv_lock);
        else n_pass++;
        n_chk++;
        if (bad != 0) $display("FAIL acq_idle_out: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_data;
        int   bad;
        int   lost;
        logic d;
        bad  = 0;
        lost = 0;
        for (int i = 0; i < 64; i++) begin
            d = 1'($urandom_range(0, 1));
            step_a(d, 1'b1);
            if (dv_a !== 1'b1 || desc_a !== d) bad++;
            if (locked_a !== 1'b1) lost++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL data_out: got %0d bad bits want 0", bad);
        else n_pass++;
        n_chk++;
        if (lost != 0) $display("FAIL data_lock: got %0d unlocked cycles want 0", lost);
        else n_pass++;
    endtask

    task automatic test_reset_midlock;
        int lock_at;
        lock_at = -1;
        step_a(1'b1, 1'b1);
        n_chk++;
        if ({locked_a, dv_a, desc_a} !== 3'b111)
            $display("FAIL midlock_pre: got %b want 111", {locked_a, dv_a, desc_a});
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({locked_a, dv_a, desc_a} !== 3'b000)
            $display("FAIL midlock_async: got %b want 000", {locked_a, dv_a, desc_a});
        else n_pass++;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 80 && lock_at < 0; i++) begin
            step_a(1'b1, 1'b1);
            if (locked_a === 1'b1) lock_at = i;
        end
        n_chk++;
        if (lock_at < 30 || lock_at > 60)
            $display("FAIL midlock_reacq: got lock at bit %0d want 30..60", lock_at);
        else n_pass++;
    endtask

    task automatic test_valid_gaps;
        int   n;
        int   lock_n;
        int   dv_bad;
        int   bad;
        logic v;
        logic d;
        n      = 0;
        lock_n = -1;
        dv_bad = 0;
        bad    = 0;
        apply_reset;
        tx_a = 11'h7ff;
        for (int c = 0; c < 200 && lock_n < 0; c++) begin
            v = (c % 2 == 0);
            step_a(1'b1, v);
            if (v) n++;
            if (dv_a !== 1'b0) dv_bad++;
            if (locked_a === 1'b1) lock_n = n;
        end
        n_chk++;
        if (lock_n != 41) $display("FAIL gap_lock_bits: got %0d want 41", lock_n);
        else n_pass++;
        n_chk++;
        if (dv_bad != 0) $display("FAIL gap_acq_dv: got %0d want 0", dv_bad);
        else n_pass++;
        for (int c = 0; c < 80; c++) begin
            v = (c % 2 == 1);
            d = 1'($urandom_range(0, 1));
            step_a(d, v);
            if (dv_a !== v || (v && desc_a !== d)) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL gap_data: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int lock_at;
        int fall;
        int relock;
        int drops;
        lock_at = -1;
        fall    = -1;
        relock  = -1;
        drops   = 0;
        apply_reset;
        tx_b = 11'h7ff;
        for (int i = 0; i < 60 && lock_at < 0; i++) begin
            step_b(1'b1, 1'b1);
            if (locked_b === 1'b1) lock_at = i;
        end
        n_chk++;
        if (lock_at != 40) $display("FAIL tmo_lock_bit: got %0d want 40", lock_at);
        else n_pass++;
        // runs of three ones never restart the timer
        for (int i = 0; i < 120 && fall < 0; i++) begin
            step_b(i % 4 != 3, 1'b1);
            if (locked_b !== 1'b1) fall = i;
        end
        n_chk++;
        if (fall != 99) $display("FAIL tmo_drop_bit: got %0d want 99", fall);
        else n_pass++;
        for (int i = 0; i < 60 && relock < 0; i++) begin
            step_b(1'b1, 1'b1);
            if (locked_b === 1'b1) relock = i;
        end
        n_chk++;
        if (relock != 29) $display("FAIL tmo_relock_bit: got %0d want 29", relock);
        else n_pass++;
        // the 29th one of the run coincides with the 100th timed bit
        for (int i = 0; i < 100; i++) begin
            step_b((i < 71) ? (i % 4 != 2) : 1'b1, 1'b1);
            if (locked_b !== 1'b1) drops++;
        end
        n_chk++;
        if (drops != 0) $display("FAIL tmo_same_bit: got %0d unlocked cycles want 0", drops);
        else n_pass++;
        fall = -1;
        for (int i = 0; i < 120 && fall < 0; i++) begin
            step_b(i % 4 != 3, 1'b1);
            if (locked_b !== 1'b1) fall = i;
        end
        n_chk++;
        if (fall != 99) $display("FAIL tmo_after_restart: got %0d want 99", fall);
        else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        tx_a   = 11'h7ff;
        tx_b   = 11'h7ff;
        test_reset;
        test_stuck_high;
        test_acquire;
        test_data;
        test_reset_midlock;
        test_valid_gaps;
        test_timeout;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
